cuppa_chan_reg_bank: RTL
========================

// Module: cuppa_chan_reg_bank
// PURPOSE
// Parametrised per-channel register bank on the crs_master y-bus (y_adr/y_wr/y_wr_data/y_rd_data).
// Replaces hand-coded per-digitizer trig/wvb register cases with N_CHANNELS identical pages.
// Adds a global simultaneous-arm register and a two-slot ping-pong readout-DPRAM handshake.
// Top level muxes rd_data when rd_hit=1; otherwise scratch/readout DPRAM data is returned.
// PARAMETERS
// N_CHANNELS  2       number of channel pages (1..16)
// CH_BASE     12'hf00 address of channel 0 offset 0; channel c page = CH_BASE + 16*c
// THR_W       12      trigger threshold width (1..16)
// GLB_BASE    12'hdf0 base of global registers (offsets 0..3)
// PORTS
// clk            in   1             system clock
// rst            in   1             synchronous, active-high reset
// y_adr          in   12            register address
// y_wr           in   1             write strobe, 1 cycle
// y_wr_data      in   16            write data
// rd_data        out  16            combinational read data for y_adr
// rd_hit         out  1             y_adr decodes to this block
// trig_ctl       out  5*N           per ch {ext_en,thr_en,lt,gt,et}
// trig_thr       out  THR_W*N       per ch threshold
// trig_run       out  N             1-cycle pulse per ch
// wvb_pre/post/cnst/test out 6*N/15*N/15*N/15*N   waveform-buffer config
// wvb_mode       out  2*N           per ch {cnst_run,trig_mode}
// wvb_arm        out  N             1-cycle pulse per ch
// wvb_rst        out  N             level, per ch
// wvb_status     in   3*N           per ch {hdr_full,overflow,armed}
// wvb_n_wvf      in   10*N          per ch waveforms in buffer
// wvb_wused      in   16*N          per ch words used
// rdout_run      in   1             reader: slot filled (pulse)
// rdout_len      in   16            reader: length of filled slot
// rdout_slot     out  1             slot reader must write next
// dpram_busy     out  1             both slots full; reader must stall
// BEHAVIOUR
// - Channel c, offset o (y_adr = CH_BASE+16c+o, c<N_CHANNELS): 0 TRIG_CTL rw[4:0]; 1 THR rw[THR_W-1:0];
//   2 PRE rw[5:0]; 3 POST rw[14:0]; 4 CNST rw[14:0]; 5 TEST rw[14:0]; 6 MODE rw[1:0];
//   7 CTRL w: bit0->trig_run pulse, bit1->wvb_arm pulse, bit2->wvb_rst level (reads {13'b0,wvb_rst,2'b0});
//   8 STATUS ro; 9 N_WVF ro; 10 WUSED ro; 11-15 read 0, rd_hit=1, writes ignored.
// - Global: GLB+0 ARM_ALL w: bit0=1 pulses wvb_arm on all ch same cycle, reads 0; GLB+1 RUN_ALL likewise for trig_run;
//   GLB+2 DPRAM_LEN ro (length of head slot, 0 if empty); GLB+3 DPRAM_DONE w bit0=1 releases head slot,
//   reads {13'b0,head_idx,count[1:0]}.
// - Reads unused bits 0; rd_hit=0 and rd_data=0 outside decoded space (incl. pages c>=N_CHANNELS).
// - Write latency: register/output updates on the clk edge where y_wr=1; pulses high exactly that next cycle only.
// - Per-channel CTRL pulse and ARM_ALL same cycle impossible (single bus); pulses OR'd by construction.
// - Ping-pong FSM: count in {0,1,2}, wr_idx, head_idx, len[2].
//   rdout_run & count<2: len[wr_idx]<=rdout_len, wr_idx toggles, count+1. rdout_run & count==2: dropped.
//   DONE & count>0: head_idx toggles, count-1. DONE & count==0: ignored.
//   Simultaneous run & done with count==2: release and capture both apply, count stays 2.
//   dpram_busy = (count==2); rdout_slot = wr_idx.
// - Reset: all rw regs 0, pulses 0, wvb_rst 0, count 0, wr_idx 0, head_idx 0, len 0. Reset mid-operation discards slots.
// TESTING
// - Write 16'h001f to CH_BASE+16*1+0 -> trig_ctl[9:5]=5'h1f next cycle, ch0 unchanged; readback 0x001f.
// - Write 16'hffff to THR of ch0 with THR_W=12 -> trig_thr[11:0]=12'hfff, read 0x0fff.
// - Write 1 to GLB+0 -> wvb_arm all bits high for exactly 1 cycle; GLB+0 reads 0.
// - rdout_run len 100 then 200 -> busy=1, GLB+2=100; DONE -> GLB+2=200, busy=0, rdout_slot=0.
// - count==2, rdout_run + DONE same cycle -> count stays 2, new len in freed slot; third run with busy dropped.
// - Read CH_BASE+16*N_CHANNELS -> rd_hit=0, rd_data=0; rst mid-fill -> count=0, busy=0, GLB+2=0.

Source files
------------

// File: rtl/cuppa_chan_reg_bank.sv
// Per-channel trigger/waveform-buffer register pages, global arm/run strobes and
// a two-slot ping-pong readout-DPRAM handshake on the crs_master y-bus.
module cuppa_chan_reg_bank #(
    parameter int          N_CHANNELS = 2,
    parameter logic [11:0] CH_BASE    = 12'hf00,
    parameter int          THR_W      = 12,
    parameter logic [11:0] GLB_BASE   = 12'hdf0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [11:0]                   y_adr,
    input  logic                          y_wr,
    input  logic [15:0]                   y_wr_data,
    output logic [15:0]                   rd_data,
    output logic                          rd_hit,
    output logic [5*N_CHANNELS-1:0]       trig_ctl,
    output logic [THR_W*N_CHANNELS-1:0]   trig_thr,
    output logic [N_CHANNELS-1:0]         trig_run,
    output logic [6*N_CHANNELS-1:0]       wvb_pre,
    output logic [15*N_CHANNELS-1:0]      wvb_post,
    output logic [15*N_CHANNELS-1:0]      wvb_cnst,
    output logic [15*N_CHANNELS-1:0]      wvb_test,
    output logic [2*N_CHANNELS-1:0]       wvb_mode,
    output logic [N_CHANNELS-1:0]         wvb_arm,
    output logic [N_CHANNELS-1:0]         wvb_rst,
    input  logic [3*N_CHANNELS-1:0]       wvb_status,
    input  logic [10*N_CHANNELS-1:0]      wvb_n_wvf,
    input  logic [16*N_CHANNELS-1:0]      wvb_wused,
    input  logic                          rdout_run,
    input  logic [15:0]                   rdout_len,
    output logic                          rdout_slot,
    output logic                          dpram_busy
);

    localparam logic [3:0] OFF_TRIG_CTL = 4'd0;
    localparam logic [3:0] OFF_THR      = 4'd1;
    localparam logic [3:0] OFF_PRE      = 4'd2;
    localparam logic [3:0] OFF_POST     = 4'd3;
    localparam logic [3:0] OFF_CNST     = 4'd4;
    localparam logic [3:0] OFF_TEST     = 4'd5;
    localparam logic [3:0] OFF_MODE     = 4'd6;
    localparam logic [3:0] OFF_CTRL     = 4'd7;
    localparam logic [3:0] OFF_STATUS   = 4'd8;
    localparam logic [3:0] OFF_N_WVF    = 4'd9;
    localparam logic [3:0] OFF_WUSED    = 4'd10;

    localparam logic [1:0] GLB_ARM_ALL  = 2'd0;
    localparam logic [1:0] GLB_RUN_ALL  = 2'd1;
    localparam logic [1:0] GLB_LEN      = 2'd2;
    localparam logic [1:0] GLB_DONE     = 2'd3;

    logic [5*N_CHANNELS-1:0]     r_trig_ctl;
    logic [THR_W*N_CHANNELS-1:0] r_trig_thr;
    logic [N_CHANNELS-1:0]       r_trig_run;
    logic [6*N_CHANNELS-1:0]     r_wvb_pre;
    logic [15*N_CHANNELS-1:0]    r_wvb_post;
    logic [15*N_CHANNELS-1:0]    r_wvb_cnst;
    logic [15*N_CHANNELS-1:0]    r_wvb_test;
    logic [2*N_CHANNELS-1:0]     r_wvb_mode;
    logic [N_CHANNELS-1:0]       r_wvb_arm;
    logic [N_CHANNELS-1:0]       r_wvb_rst;

    logic [1:0]  r_count;
    logic        r_wr_idx;
    logic        r_head_idx;
    logic [15:0] r_len [2];

    logic [11:0]           w_ch_off;
    logic [11:0]           w_glb_off;
    logic [3:0]            w_reg;
    logic [N_CHANNELS-1:0] w_ch_sel;
    logic [N_CHANNELS-1:0] w_ctrl_wr;
    logic                  w_glb_sel;
    logic                  w_arm_all;
    logic                  w_run_all;
    logic                  w_done;
    logic                  w_release;
    logic                  w_capture;
    logic                  w_unused;

    assign w_ch_off  = y_adr - CH_BASE;
    assign w_glb_off = y_adr - GLB_BASE;
    assign w_reg     = w_ch_off[3:0];
    assign w_glb_sel = (y_adr >= GLB_BASE) && (w_glb_off < 12'd4);

    always_comb begin
        w_ch_sel  = '0;
        w_ctrl_wr = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            w_ch_sel[c]  = (y_adr >= CH_BASE) && (w_ch_off[11:4] == 8'(c));
            w_ctrl_wr[c] = y_wr && w_ch_sel[c] && (w_reg == OFF_CTRL);
        end
    end

    assign w_arm_all = y_wr && w_glb_sel && (w_glb_off[1:0] == GLB_ARM_ALL) && y_wr_data[0];
    assign w_run_all = y_wr && w_glb_sel && (w_glb_off[1:0] == GLB_RUN_ALL) && y_wr_data[0];
    assign w_done    = y_wr && w_glb_sel && (w_glb_off[1:0] == GLB_DONE)    && y_wr_data[0];

    // A release frees the head slot in the same edge, so a capture that would
    // otherwise be dropped on a full buffer lands in the slot just freed.
    assign w_release = w_done && (r_count != 2'd0);
    assign w_capture = rdout_run && ((r_count != 2'd2) || w_release);

    // Bit 15 of the write bus has no destination in any register.
    assign w_unused = &{1'b0, y_wr_data[15]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the bus and of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_ctl <= '0;
            r_trig_thr <= '0;
            r_trig_run <= '0;
            r_wvb_pre  <= '0;
            r_wvb_post <= '0;
            r_wvb_cnst <= '0;
            r_wvb_test <= '0;
            r_wvb_mode <= '0;
            r_wvb_arm  <= '0;
            r_wvb_rst  <= '0;
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                r_trig_run[c] <= (w_ctrl_wr[c] && y_wr_data[0]) || w_run_all;
                r_wvb_arm[c]  <= (w_ctrl_wr[c] && y_wr_data[1]) || w_arm_all;
                if (y_wr && w_ch_sel[c]) begin
                    case (w_reg)
                        OFF_TRIG_CTL: r_trig_ctl[5*c +: 5]         <= y_wr_data[4:0];
                        OFF_THR:      r_trig_thr[THR_W*c +: THR_W] <= y_wr_data[THR_W-1:0];
                        OFF_PRE:      r_wvb_pre[6*c +: 6]          <= y_wr_data[5:0];
                        OFF_POST:     r_wvb_post[15*c +: 15]       <= y_wr_data[14:0];
                        OFF_CNST:     r_wvb_cnst[15*c +: 15]       <= y_wr_data[14:0];
                        OFF_TEST:     r_wvb_test[15*c +: 15]       <= y_wr_data[14:0];
                        OFF_MODE:     r_wvb_mode[2*c +: 2]         <= y_wr_data[1:0];
                        OFF_CTRL:     r_wvb_rst[c]                 <= y_wr_data[2];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_wr_idx   <= 1'b0;
            r_head_idx <= 1'b0;
            r_len[0]   <= 16'd0;
            r_len[1]   <= 16'd0;
        end else begin
            if (w_capture) begin
                r_len[r_wr_idx] <= rdout_len;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_release) begin
                r_head_idx <= ~r_head_idx;
            end
            case ({w_capture, w_release})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (w_ch_sel[c]) begin
                rd_hit = 1'b1;
                case (w_reg)
                    OFF_TRIG_CTL: rd_data[4:0]       = r_trig_ctl[5*c +: 5];
                    OFF_THR:      rd_data[THR_W-1:0] = r_trig_thr[THR_W*c +: THR_W];
                    OFF_PRE:      rd_data[5:0]       = r_wvb_pre[6*c +: 6];
                    OFF_POST:     rd_data[14:0]      = r_wvb_post[15*c +: 15];
                    OFF_CNST:     rd_data[14:0]      = r_wvb_cnst[15*c +: 15];
                    OFF_TEST:     rd_data[14:0]      = r_wvb_test[15*c +: 15];
                    OFF_MODE:     rd_data[1:0]       = r_wvb_mode[2*c +: 2];
                    OFF_CTRL:     rd_data[2]         = r_wvb_rst[c];
                    OFF_STATUS:   rd_data[2:0]       = wvb_status[3*c +: 3];
                    OFF_N_WVF:    rd_data[9:0]       = wvb_n_wvf[10*c +: 10];
                    OFF_WUSED:    rd_data            = wvb_wused[16*c +: 16];
                    default: ;
                endcase
            end
        end
        if (w_glb_sel) begin
            rd_hit = 1'b1;
            case (w_glb_off[1:0])
                GLB_LEN:  rd_data      = (r_count == 2'd0) ? 16'd0 : r_len[r_head_idx];
                GLB_DONE: rd_data[2:0] = {r_head_idx, r_count};
                default: ;
            endcase
        end
    end

    assign trig_ctl   = r_trig_ctl;
    assign trig_thr   = r_trig_thr;
    assign trig_run   = r_trig_run;
    assign wvb_pre    = r_wvb_pre;
    assign wvb_post   = r_wvb_post;
    assign wvb_cnst   = r_wvb_cnst;
    assign wvb_test   = r_wvb_test;
    assign wvb_mode   = r_wvb_mode;
    assign wvb_arm    = r_wvb_arm;
    assign wvb_rst    = r_wvb_rst;
    assign rdout_slot = r_wr_idx;
    assign dpram_busy = (r_count == 2'd2);

endmodule
